// File: rtl/hs_npu_inference_ctrl.sv
// rtl/hs_npu_inference_ctrl.sv - NPU inference job sequencer (flush/load/compute/drain); optional watchdog via HS_NPU_INFER_WATCHDOG_EN
module hs_npu_inference_ctrl #(
    parameter int SIZE                 = 8,
    parameter int INPUT_FIFO_DEPTH     = 10,
    parameter int WEIGHT_SETTLE_CYCLES = SIZE,
    parameter int OUTPUT_START_DELAY   = 2 * SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_rows_i,
    input  logic [31:0] cmd_shift_i,
    input  logic        cmd_relu_i,
    input  logic        weight_push_i,
    input  logic        input_push_i,
    input  logic        result_pop_i,
    output logic        weight_accept_o,
    output logic        input_accept_o,
    output logic        flush_input_fifos,
    output logic        flush_weight_fifos,
    output logic        flush_output_fifos,
    output logic        bias_en,
    output logic        enable_weights,
    output logic        start_input_gatekeeper,
    output logic        start_output_gatekeeper,
    output logic [31:0] enable_cycles_in,
    output logic [31:0] shift_amount,
    output logic        relu_enable,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam logic [31:0] SIZE_W  = 32'(SIZE);
    localparam logic [31:0] DEPTH_W = 32'(INPUT_FIFO_DEPTH);
    localparam logic [31:0] WSC_W   = 32'(WEIGHT_SETTLE_CYCLES);
    localparam logic [31:0] OSD_W   = 32'(OUTPUT_START_DELAY);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_LOAD_W, S_LOAD_B, S_LOAD_I, S_EN_W, S_COMPUTE, S_DRAIN
    } state_t;

    state_t      state;
    logic [31:0] rows_q;
    logic [31:0] wcnt;
    logic [31:0] icnt;
    logic [31:0] ecnt;
    logic [31:0] ccnt;
    logic [31:0] pcnt;
    logic [31:0] pcnt_nxt;

    assign pcnt_nxt = pcnt + {31'b0, result_pop_i};

`ifdef HS_NPU_INFER_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        wd_stall;

    always_comb begin
        wd_stall = 1'b0;
        case (state)
            S_LOAD_W: wd_stall = !(weight_push_i && weight_accept_o);
            S_LOAD_I: wd_stall = !(input_push_i && input_accept_o);
            S_DRAIN:  wd_stall = !result_pop_i && (pcnt < rows_q);
            default:  wd_stall = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                   <= S_IDLE;
            rows_q                  <= '0;
            wcnt                    <= '0;
            icnt                    <= '0;
            ecnt                    <= '0;
            ccnt                    <= '0;
            pcnt                    <= '0;
            cmd_ready_o             <= 1'b1;
            weight_accept_o         <= 1'b0;
            input_accept_o          <= 1'b0;
            flush_input_fifos       <= 1'b0;
            flush_weight_fifos      <= 1'b0;
            flush_output_fifos      <= 1'b0;
            bias_en                 <= 1'b0;
            enable_weights          <= 1'b0;
            start_input_gatekeeper  <= 1'b0;
            start_output_gatekeeper <= 1'b0;
            enable_cycles_in        <= '0;
            shift_amount            <= '0;
            relu_enable             <= 1'b0;
            busy_o                  <= 1'b0;
            done_o                  <= 1'b0;
            err_o                   <= 1'b0;
`ifdef HS_NPU_INFER_WATCHDOG_EN
            wd_cnt                  <= '0;
`endif
        end else begin
            done_o                  <= 1'b0;
            err_o                   <= 1'b0;
            bias_en                 <= 1'b0;
            start_input_gatekeeper  <= 1'b0;
            start_output_gatekeeper <= 1'b0;
            flush_input_fifos       <= 1'b0;
            flush_weight_fifos      <= 1'b0;
            flush_output_fifos      <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid_i && cmd_ready_o) begin
                    rows_q           <= cmd_rows_i;
                    shift_amount     <= cmd_shift_i;
                    relu_enable      <= cmd_relu_i;
                    enable_cycles_in <= cmd_rows_i + SIZE_W - 32'd1;
                    if (cmd_rows_i == 32'd0) begin
                        done_o <= 1'b1;
                    end else if (cmd_rows_i > DEPTH_W) begin
                        err_o <= 1'b1;
                    end else begin
                        state              <= S_FLUSH;
                        flush_input_fifos  <= 1'b1;
                        flush_weight_fifos <= 1'b1;
                        flush_output_fifos <= 1'b1;
                        cmd_ready_o        <= 1'b0;
                        busy_o             <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    state           <= S_LOAD_W;
                    weight_accept_o <= 1'b1;
                    wcnt            <= '0;
                end
                S_LOAD_W: if (weight_push_i && weight_accept_o) begin
                    wcnt <= wcnt + 32'd1;
                    if (wcnt + 32'd1 == SIZE_W) begin
                        weight_accept_o <= 1'b0;
                        bias_en         <= 1'b1;
                        state           <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    state          <= S_LOAD_I;
                    input_accept_o <= 1'b1;
                    icnt           <= '0;
                end
                S_LOAD_I: if (input_push_i && input_accept_o) begin
                    icnt <= icnt + 32'd1;
                    if (icnt + 32'd1 == rows_q) begin
                        input_accept_o <= 1'b0;
                        enable_weights <= 1'b1;
                        ecnt           <= '0;
                        state          <= S_EN_W;
                    end
                end
                S_EN_W: begin
                    ecnt <= ecnt + 32'd1;
                    if (ecnt + 32'd1 == WSC_W) begin
                        enable_weights         <= 1'b0;
                        start_input_gatekeeper <= 1'b1;
                        ccnt                   <= '0;
                        pcnt                   <= '0;
                        state                  <= S_COMPUTE;
                    end
                end
                // Pops are already counted here so a fast consumer is never lost.
                S_COMPUTE: begin
                    ccnt <= ccnt + 32'd1;
                    pcnt <= pcnt_nxt;
                    if (ccnt + 32'd1 == OSD_W) start_output_gatekeeper <= 1'b1;
                    if (start_output_gatekeeper) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    pcnt <= pcnt_nxt;
                    if (pcnt_nxt >= rows_q) begin
                        done_o      <= 1'b1;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef HS_NPU_INFER_WATCHDOG_EN
            wd_cnt <= wd_stall ? wd_cnt + 16'd1 : 16'd0;
            // Counter would reach 0xFFFF this edge: abort the job and flush the datapath.
            if (wd_stall && wd_cnt == 16'hFFFE) begin
                wd_cnt             <= '0;
                err_o              <= 1'b1;
                flush_input_fifos  <= 1'b1;
                flush_weight_fifos <= 1'b1;
                flush_output_fifos <= 1'b1;
                weight_accept_o    <= 1'b0;
                input_accept_o     <= 1'b0;
                busy_o             <= 1'b0;
                cmd_ready_o        <= 1'b1;
                state              <= S_IDLE;
            end
`endif
        end
    end
endmodule

// File: tb/tb_hs_npu_inference_ctrl.sv
// tb/tb_hs_npu_inference_ctrl.sv - self-checking bench for hs_npu_inference_ctrl
module tb_hs_npu_inference_ctrl;
    localparam int SIZE  = 8;
    localparam int DEPTH = 10;
    localparam int BIG   = 1 << 30;
    localparam int W_WACC = 0, W_IACC = 1, W_SIN = 2, W_SOUT = 3, W_DONE = 4, W_ERR = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_rows_i = '0;
    logic [31:0] cmd_shift_i = '0;
    logic        cmd_relu_i = 1'b0;
    logic        weight_push_i = 1'b0;
    logic        input_push_i = 1'b0;
    logic        result_pop_i = 1'b0;
    logic        weight_accept_o, input_accept_o;
    logic        flush_input_fifos, flush_weight_fifos, flush_output_fifos;
    logic        bias_en, enable_weights, start_input_gatekeeper, start_output_gatekeeper;
    logic [31:0] enable_cycles_in, shift_amount;
    logic        relu_enable, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    hs_npu_inference_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_rows_i(cmd_rows_i), .cmd_shift_i(cmd_shift_i), .cmd_relu_i(cmd_relu_i),
        .weight_push_i(weight_push_i), .input_push_i(input_push_i), .result_pop_i(result_pop_i),
        .weight_accept_o(weight_accept_o), .input_accept_o(input_accept_o),
        .flush_input_fifos(flush_input_fifos), .flush_weight_fifos(flush_weight_fifos),
        .flush_output_fifos(flush_output_fifos), .bias_en(bias_en),
        .enable_weights(enable_weights), .start_input_gatekeeper(start_input_gatekeeper),
        .start_output_gatekeeper(start_output_gatekeeper), .enable_cycles_in(enable_cycles_in),
        .shift_amount(shift_amount), .relu_enable(relu_enable),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit cmp_en = 1'b1;

    // Job model: event stamps (edge numbers) for each phase boundary of the current job.
    bit m_busy = 1'b0;
    int t_acc = BIG, t_wd = BIG, t_id = BIG;
    int m_rows = 0, wcnt = 0, icnt = 0, pcnt = 0;
    bit e_ready, e_busy, e_done, e_err, e_flush, e_wacc, e_iacc, e_bias, e_enw, e_sin, e_sout;
    bit e_relu = 1'b0;
    logic [31:0] e_shift = '0, e_ecyc = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        e_done = 1'b0;
        e_err = 1'b0;
        e_flush = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            t_acc = BIG; t_wd = BIG; t_id = BIG;
            e_shift = '0; e_relu = 1'b0; e_ecyc = '0;
        end else if (!m_busy) begin
            if (cmd_valid_i) begin
                e_shift = cmd_shift_i;
                e_relu = cmd_relu_i;
                e_ecyc = cmd_rows_i + 32'(SIZE) - 32'd1;
                if (cmd_rows_i == 0) e_done = 1'b1;
                else if (cmd_rows_i > 32'(DEPTH)) e_err = 1'b1;
                else begin
                    m_busy = 1'b1;
                    m_rows = int'(cmd_rows_i);
                    t_acc = cyc; t_wd = BIG; t_id = BIG;
                    wcnt = 0; icnt = 0; pcnt = 0;
                    e_flush = 1'b1;
                end
            end
        end else begin
            if (t_wd == BIG) begin
                if (cyc >= t_acc + 2 && weight_push_i) begin
                    wcnt++;
                    if (wcnt == SIZE) t_wd = cyc;
                end
            end else if (t_id == BIG) begin
                if (cyc >= t_wd + 2 && input_push_i) begin
                    icnt++;
                    if (icnt == m_rows) t_id = cyc;
                end
            end else begin
                if (cyc >= t_id + SIZE + 1 && result_pop_i) pcnt++;
                if (cyc >= t_id + 3 * SIZE + 2 && pcnt >= m_rows) begin
                    m_busy = 1'b0;
                    e_done = 1'b1;
                end
            end
        end
        e_ready = !m_busy;
        e_busy  = m_busy;
        e_wacc  = m_busy && t_wd == BIG && cyc >= t_acc + 1;
        e_bias  = (cyc == t_wd);
        e_iacc  = m_busy && t_wd != BIG && t_id == BIG && cyc >= t_wd + 1;
        e_enw   = t_id != BIG && cyc >= t_id && cyc <= t_id + SIZE - 1;
        e_sin   = (cyc == t_id + SIZE);
        e_sout  = (cyc == t_id + 3 * SIZE);
    end

    logic [12:0] act_bits, exp_bits;
    always @(negedge clk) begin
        if (cmp_en && cyc > 0) begin
            act_bits = {cmd_ready_o, busy_o, done_o, err_o, flush_input_fifos, flush_weight_fifos,
                        flush_output_fifos, weight_accept_o, input_accept_o, bias_en, enable_weights,
                        start_input_gatekeeper, start_output_gatekeeper};
            exp_bits = {e_ready, e_busy, e_done, e_err, e_flush, e_flush, e_flush, e_wacc, e_iacc,
                        e_bias, e_enw, e_sin, e_sout};
            total++;
            if (act_bits !== exp_bits) begin
                bad++;
                $display("FAIL ctrl_bits cyc=%0d got=%b want=%b", cyc, act_bits, exp_bits);
            end
            total++;
            if ({relu_enable, shift_amount, enable_cycles_in} !== {e_relu, e_shift, e_ecyc}) begin
                bad++;
                $display("FAIL latched cyc=%0d got relu=%0d shift=%0d ecyc=%0d want relu=%0d shift=%0d ecyc=%0d",
                         cyc, relu_enable, shift_amount, enable_cycles_in, e_relu, e_shift, e_ecyc);
            end
        end
    end

    int n_flush, n_bias, n_enw, n_done, n_err, c_sin, c_sout, c_done;
    always @(negedge clk) begin
        if (flush_input_fifos) n_flush++;
        if (bias_en) n_bias++;
        if (enable_weights) n_enw++;
        if (done_o) begin n_done++; c_done = cyc; end
        if (err_o) n_err++;
        if (start_input_gatekeeper) c_sin = cyc;
        if (start_output_gatekeeper) c_sout = cyc;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clear_mon();
        n_flush = 0; n_bias = 0; n_enw = 0; n_done = 0; n_err = 0;
        c_sin = -1; c_sout = -1; c_done = -1;
    endtask

    function automatic bit sig_of(input int sel);
        case (sel)
            W_WACC:  return weight_accept_o;
            W_IACC:  return input_accept_o;
            W_SIN:   return start_input_gatekeeper;
            W_SOUT:  return start_output_gatekeeper;
            W_DONE:  return done_o;
            W_ERR:   return err_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int limit, input string name);
        int n = 0;
        while (!sig_of(sel) && n < limit) begin
            step();
            n++;
        end
        if (!sig_of(sel)) check({"timeout_", name}, 0, 1);
    endtask

    task automatic issue_cmd(input int rows, input int shift, input bit relu);
        cmd_valid_i = 1'b1;
        cmd_rows_i = 32'(rows);
        cmd_shift_i = 32'(shift);
        cmd_relu_i = relu;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic push_w(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i % 3 == 1) begin weight_push_i = 1'b0; step(); end
            weight_push_i = 1'b1;
            step();
        end
        weight_push_i = 1'b0;
    endtask

    task automatic push_i(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i % 2 == 1) begin input_push_i = 1'b0; step(); end
            input_push_i = 1'b1;
            step();
        end
        input_push_i = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            result_pop_i = 1'b1;
            step();
        end
        result_pop_i = 1'b0;
    endtask

    // Full job; stray=1 pokes a command while busy, early=1 pops during COMPUTE.
    task automatic run_job(input int rows, input int shift, input bit relu, input int extra_w,
                           input bit gaps, input bit early, input bit stray);
        clear_mon();
        issue_cmd(rows, shift, relu);
        wait_sig(W_WACC, 20, "wacc");
        push_w(SIZE + extra_w, gaps);
        wait_sig(W_IACC, 20, "iacc");
        if (stray) begin
            cmd_valid_i = 1'b1; cmd_rows_i = 0;
            step();
            cmd_valid_i = 1'b0;
        end
        push_i(rows, gaps);
        if (early) begin
            wait_sig(W_SIN, 40, "sin");
            pop_n(rows);
            wait_sig(W_DONE, 60, "done");
        end else begin
            wait_sig(W_SOUT, 60, "sout");
            step(); step();
            pop_n(rows);
            check("done_after_last_pop", int'(done_o), 1);
        end
        step();
    endtask

    initial begin
        clear_mon();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_ready", int'(cmd_ready_o), 1);
        check("reset_busy", int'(busy_o), 0);

        // Nominal job: rows=4, shift=3, relu=1
        run_job(4, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("nom_flush_cycles", n_flush, 1);
        check("nom_bias_cycles", n_bias, 1);
        check("nom_enw_cycles", n_enw, 8);
        check("nom_enable_cycles_in", int'(enable_cycles_in), 11);
        check("nom_sout_minus_sin", c_sout - c_sin, 16);
        check("nom_done_count", n_done, 1);
        check("nom_shift", int'(shift_amount), 3);
        check("nom_relu", int'(relu_enable), 1);

        // Zero-row command
        clear_mon();
        issue_cmd(0, 5, 1'b0);
        check("zero_done_next", int'(done_o), 1);
        repeat (3) step();
        check("zero_done_count", n_done, 1);
        check("zero_flush", n_flush, 0);
        check("zero_busy", int'(busy_o), 0);
        check("zero_ecyc", int'(enable_cycles_in), 7);

        // Oversized then maximum-size job
        clear_mon();
        issue_cmd(11, 2, 1'b1);
        check("over_err_next", int'(err_o), 1);
        repeat (3) step();
        check("over_err_count", n_err, 1);
        check("over_flush", n_flush, 0);
        check("over_ready", int'(cmd_ready_o), 1);
        run_job(10, 6, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("max_done_count", n_done, 1);
        check("max_enw_cycles", n_enw, 8);
        check("max_ecyc", int'(enable_cycles_in), 17);

        // Ninth weight push ignored, early pops, command while busy ignored
        run_job(2, 1, 1'b1, 1, 1'b0, 1'b1, 1'b1);
        check("extra_bias_count", n_bias, 1);
        check("extra_done_count", n_done, 1);
        check("early_done_gap", c_done - c_sin, 18);

        // Reset mid-DRAIN
        clear_mon();
        issue_cmd(4, 7, 1'b0);
        wait_sig(W_WACC, 20, "rst_wacc");
        push_w(SIZE, 1'b0);
        wait_sig(W_IACC, 20, "rst_iacc");
        push_i(4, 1'b0);
        wait_sig(W_SOUT, 60, "rst_sout");
        step(); step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_ready", int'(cmd_ready_o), 1);
        check("rst_busy", int'(busy_o), 0);
        check("rst_shift", int'(shift_amount), 0);
        repeat (4) step();
        check("rst_no_done", n_done, 0);

`ifdef HS_NPU_INFER_WATCHDOG_EN
        begin
            int c_iacc;
            cmp_en = 1'b0;
            clear_mon();
            issue_cmd(3, 0, 1'b0);
            wait_sig(W_WACC, 20, "wd_wacc");
            push_w(SIZE, 1'b0);
            wait_sig(W_IACC, 20, "wd_iacc");
            c_iacc = cyc;
            wait_sig(W_ERR, 70000, "wd_err");
            check("wd_err_delay", cyc - c_iacc, 65535);
            check("wd_flush", int'(flush_input_fifos & flush_weight_fifos & flush_output_fifos), 1);
            step();
            check("wd_ready", int'(cmd_ready_o), 1);
            check("wd_busy", int'(busy_o), 0);
            check("wd_no_done", n_done, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hs_npu_inference_ctrl.md
Name: hs_npu_inference_ctrl

Overview:
Job sequencer for the NPU inference datapath (MM unit, accumulators, activations, output FIFOs). It accepts one job command per handshake and walks the datapath through a fixed sequence: flush, weight load, bias load, input load, weight enable, compute, output drain. It drives every control input of the inference datapath and reports completion to the host-side command logic.

Parameters:
SIZE, 8, systolic array rows/columns; number of weight rows per job
INPUT_FIFO_DEPTH, 10, maximum input rows per job
WEIGHT_SETTLE_CYCLES, SIZE, cycles enable_weights is held high
OUTPUT_START_DELAY, 2*SIZE, cycles from start_input_gatekeeper to start_output_gatekeeper

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
cmd_valid_i  in  1  job command valid
cmd_ready_o  out  1  controller can accept a job (high only in IDLE)
cmd_rows_i  in  32 (uword)  input rows in this job
cmd_shift_i  in  32 (uword)  activation shift amount
cmd_relu_i  in  1  ReLU enable for this job
weight_push_i  in  1  one weight row accepted by the weight FIFOs this cycle
input_push_i  in  1  one input row accepted by the input FIFOs this cycle
result_pop_i  in  1  one result row popped from the output FIFOs this cycle
weight_accept_o  out  1  producer may push weight rows
input_accept_o  out  1  producer may push input rows
flush_input_fifos  out  1  datapath control
flush_weight_fifos  out  1  datapath control
flush_output_fifos  out  1  datapath control
bias_en  out  1  single-cycle bias load strobe
enable_weights  out  1  datapath control
start_input_gatekeeper  out  1  single-cycle strobe
start_output_gatekeeper  out  1  single-cycle strobe
enable_cycles_in  out  32 (uword)  gatekeeper enable length, stable for the whole job
shift_amount  out  32 (uword)  latched job shift
relu_enable  out  1  latched job ReLU flag
busy_o  out  1  high in any state except IDLE
done_o  out  1  single-cycle job complete strobe
err_o  out  1  single-cycle rejected-command strobe

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, all counters 0, all outputs 0 except cmd_ready_o=1. Reset mid-job aborts immediately; no done_o.
- All outputs are registered. Counters are 32-bit.
- IDLE: cmd_ready_o=1. On cmd_valid_i & cmd_ready_o, latch rows, shift and relu, and set enable_cycles_in = rows + SIZE - 1.
  - rows==0: done_o pulses the next cycle; stay IDLE.
  - rows > INPUT_FIFO_DEPTH: err_o pulses the next cycle; stay IDLE; no datapath activity.
  - Otherwise go to FLUSH.
- FLUSH: 1 cycle; all three flush outputs high. Go to LOAD_W.
- LOAD_W: weight_accept_o=1. Count weight_push_i. When the count reaches SIZE, deassert weight_accept_o in the same cycle as the count update and go to LOAD_B. A push that arrives while weight_accept_o=0 is ignored, not counted.
- LOAD_B: bias_en high for 1 cycle. Go to LOAD_I.
- LOAD_I: input_accept_o=1. Count input_push_i up to the latched rows, then go to EN_W.
- EN_W: enable_weights high for exactly WEIGHT_SETTLE_CYCLES cycles. Go to COMPUTE.
- COMPUTE:
  - start_input_gatekeeper pulses on the first cycle.
  - start_output_gatekeeper pulses OUTPUT_START_DELAY cycles later.
  - Go to DRAIN on the cycle after the output strobe.
- DRAIN: count result_pop_i. When the count equals rows, pulse done_o and go to IDLE. Pops seen in COMPUTE are also counted, so an early pop is not lost.
- Simultaneous cmd_valid_i while busy: ignored (cmd_ready_o=0).
- shift_amount, relu_enable and enable_cycles_in hold their latched values until the next accepted command.

Optional Feature:
Macro HS_NPU_INFER_WATCHDOG_EN.
- Defined: a 16-bit watchdog counts cycles spent in LOAD_W, LOAD_I or DRAIN without a push or pop. It clears on every push or pop and on every state change. On reaching 0xFFFF, the controller pulses err_o, pulses all three flush outputs for one cycle, and returns to IDLE with no done_o.
- Undefined: no watchdog logic; those states wait indefinitely.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-DRAIN, release → cmd_ready_o=1, busy_o=0, all strobes 0, no done_o.
- Nominal job, SIZE=8, rows=4, shift=3, relu=1:
  - 8 weight pushes and 4 input pushes are accepted.
  - Checks: flush high for 1 cycle; bias_en 1 cycle; enable_weights high exactly 8 cycles; enable_cycles_in=11.
  - start_output_gatekeeper comes 16 cycles after start_input_gatekeeper.
  - done_o comes 1 cycle after the 4th pop.
- Zero-row command → done_o the next cycle, no flush or enable activity, busy_o stays 0.
- rows=11 with INPUT_FIFO_DEPTH=10 → err_o pulse, stays IDLE. A following rows=10 job completes normally.
- Extra 9th weight push after weight_accept_o drops → not counted, and the controller proceeds to LOAD_B on the 8th push.
- With HS_NPU_INFER_WATCHDOG_EN defined: stall in LOAD_I with 0 pushes → err_o after 65535 cycles, flush pulse, return to IDLE.
